// File: rtl/lot_gate_controller.sv
// Car park entry gate sequencer and occupancy counter.
// Define LOT_STATS_EN to add the total_entries statistics output.
module lot_gate_controller #(
  parameter int CAPACITY     = 10,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIMEOUT = 16,
  parameter int CLOSE_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             enter,
  input  logic             exit,
  output logic             gate_open,
  output logic             denied,
  output logic             timeout_err,
  output logic             count_err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef LOT_STATS_EN
  ,
  output logic [15:0]      total_entries
`endif
);

  localparam int T_MAX =
    (OPEN_TIMEOUT > CLOSE_HOLD) ? OPEN_TIMEOUT : CLOSE_HOLD;
  localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TMR_W-1:0] OT_LAST =
    TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CH_LAST =
    TMR_W'(CLOSE_HOLD - 1);
  localparam logic [CNT_W-1:0] CAP_V =
    CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    HOLD,
    BLOCKED
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             gate_d;
  logic             denied_d;
  logic             tmo_d;
  logic [CNT_W-1:0] cnt_d;
  logic             cerr_d;

  // Flags come straight from the count register.
  assign full  = (count == CAP_V);
  assign empty = (count == '0);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    denied_d = 1'b0;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (full) begin
            state_d  = BLOCKED;
            denied_d = 1'b1;
          end else begin
            state_d = OPEN;
            timer_d = '0;
          end
        end
      end
      OPEN: begin
        if (enter) begin
          state_d = HOLD;
          timer_d = '0;
        end else if (timer_q == OT_LAST) begin
          state_d = HOLD;
          timer_d = '0;
          tmo_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HOLD: begin
        if (timer_q == CH_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      BLOCKED: begin
        if (!req) begin
          state_d = IDLE;
        end else if (!full) begin
          state_d = OPEN;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Gate drive is registered from the next state.
  assign gate_d = (state_d == OPEN) ||
                  (state_d == HOLD);

  always_comb begin
    cnt_d  = count;
    cerr_d = 1'b0;
    unique case ({enter, exit})
      2'b10: begin
        if (full) cerr_d = 1'b1;
        else      cnt_d  = count + CNT_W'(1);
      end
      2'b01: begin
        if (empty) cerr_d = 1'b1;
        else       cnt_d  = count - CNT_W'(1);
      end
      default: begin
        cnt_d = count;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      gate_open   <= 1'b0;
      denied      <= 1'b0;
      timeout_err <= 1'b0;
      count_err   <= 1'b0;
      count       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gate_open   <= gate_d;
      denied      <= denied_d;
      timeout_err <= tmo_d;
      count_err   <= cerr_d;
      count       <= cnt_d;
    end
  end

`ifdef LOT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      total_entries <= '0;
    end else if (enter && !exit && !full) begin
      total_entries <= total_entries + 16'd1;
    end
  end
`endif

endmodule
